// File: rtl/bcd_timer_core_if.sv
// ---------------------------------------------------------------------------
// bcd_timer_core_if
// Groups the timer core's control inputs and display/status outputs.
//   master : drives tick_1Hz, tick_flash, StartStop, ModeSel, TimeControl;
//            observes digits and status flags (tick generator / top level side)
//   slave  : the timer core itself
// Signals:
//   tick_1Hz, tick_flash         one-cycle tick enables
//   StartStop                    active-low debounced button
//   ModeSel                      0 = count up, 1 = count down
//   TimeControl [SEL_W]          preset selector
//   MinTens..SecOnes [4]         BCD display digits
//   DOT, StopLED, FlashingLED, Running, Done   status outputs
// ---------------------------------------------------------------------------
interface bcd_timer_core_if #(
    parameter int SEL_W = 3
);
    logic             tick_1Hz;
    logic             tick_flash;
    logic             StartStop;
    logic             ModeSel;
    logic [SEL_W-1:0] TimeControl;
    logic [3:0]       MinTens;
    logic [3:0]       MinOnes;
    logic [3:0]       SecTens;
    logic [3:0]       SecOnes;
    logic             DOT;
    logic             StopLED;
    logic             FlashingLED;
    logic             Running;
    logic             Done;

    modport master (
        output tick_1Hz, tick_flash, StartStop, ModeSel, TimeControl,
        input  MinTens, MinOnes, SecTens, SecOnes,
        input  DOT, StopLED, FlashingLED, Running, Done
    );

    modport slave (
        input  tick_1Hz, tick_flash, StartStop, ModeSel, TimeControl,
        output MinTens, MinOnes, SecTens, SecOnes,
        output DOT, StopLED, FlashingLED, Running, Done
    );
endinterface

// File: rtl/bcd_timer_core.sv
// ---------------------------------------------------------------------------
// bcd_timer_core
// Two-mode minutes:seconds timer. Mode A counts up from 00:00 to preset:00,
// Mode B counts down from preset:00 to 00:00. Time advances on one-cycle
// tick enables; the digits are kept directly in BCD.
// Ports:
//   CLK_50MHz  system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        bcd_timer_core_if.slave (ticks, button, config in; digits and
//              status out)
// ---------------------------------------------------------------------------
module bcd_timer_core #(
    parameter int SEL_W      = 3,
    parameter int BASE_MIN   = 1,
    parameter int MAX_MIN    = 99,
    parameter int LONG_TICKS = 2
) (
    input  logic              CLK_50MHz,
    input  logic              rst_n,
    bcd_timer_core_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam int HOLD_W = $clog2(LONG_TICKS + 1);

    // Preset minutes as two BCD digits, clamped to MAX_MIN.
    function automatic logic [7:0] presetBcd(input logic [SEL_W-1:0] sel);
        int m;
        m = BASE_MIN + int'(sel);
        if (m > MAX_MIN) m = MAX_MIN;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [15:0] startValue(input logic mode, input logic [SEL_W-1:0] sel);
        return mode ? {presetBcd(sel), 8'h00} : 16'h0000;
    endfunction

    // One second forward with BCD carries (seconds wrap at 59).
    function automatic logic [15:0] countUp(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so == 4'd9) begin
            so = 4'd0;
            if (st == 4'd5) begin
                st = 4'd0;
                if (mo == 4'd9) begin
                    mo = 4'd0;
                    mt = mt + 4'd1;
                end else begin
                    mo = mo + 4'd1;
                end
            end else begin
                st = st + 4'd1;
            end
        end else begin
            so = so + 4'd1;
        end
        return {mt, mo, st, so};
    endfunction

    // One second backward with the mirrored BCD borrows.
    function automatic logic [15:0] countDown(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so == 4'd0) begin
            so = 4'd9;
            if (st == 4'd0) begin
                st = 4'd5;
                if (mo == 4'd0) begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end else begin
                    mo = mo - 4'd1;
                end
            end else begin
                st = st - 4'd1;
            end
        end else begin
            so = so - 4'd1;
        end
        return {mt, mo, st, so};
    endfunction

    state_t            state, nextState;
    logic [15:0]       timeReg, nextTime;
    logic              dotReg, nextDot;
    logic              flashReg, nextFlash;
    logic [HOLD_W-1:0] holdCnt, nextHold;
    logic              btnPrev, pressReg;
    logic              modePrev;
    logic [SEL_W-1:0]  selPrev;
    logic              cfgChange;
    logic [15:0]       startVal, terminalVal, stepped;

    assign startVal    = startValue(bus.ModeSel, bus.TimeControl);
    assign terminalVal = bus.ModeSel ? 16'h0000 : {presetBcd(bus.TimeControl), 8'h00};
    assign stepped     = bus.ModeSel ? countDown(timeReg) : countUp(timeReg);
    assign cfgChange   = (bus.ModeSel != modePrev) || (bus.TimeControl != selPrev);

    // Input registers: falling-edge press detect and previous configuration.
    // The config registers load the live inputs in reset so that leaving
    // reset does not look like a configuration change.
    always_ff @(posedge CLK_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            btnPrev  <= 1'b1;
            pressReg <= 1'b0;
            modePrev <= bus.ModeSel;
            selPrev  <= bus.TimeControl;
        end else begin
            btnPrev  <= bus.StartStop;
            pressReg <= btnPrev & ~bus.StartStop;
            modePrev <= bus.ModeSel;
            selPrev  <= bus.TimeControl;
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timeReg  <= startVal;
            dotReg   <= 1'b1;
            flashReg <= 1'b0;
            holdCnt  <= '0;
        end else begin
            state    <= nextState;
            timeReg  <= nextTime;
            dotReg   <= nextDot;
            flashReg <= nextFlash;
            holdCnt  <= nextHold;
        end
    end

    always_comb begin
        nextState = state;
        nextTime  = timeReg;
        nextDot   = dotReg;
        nextFlash = 1'b0;
        nextHold  = '0;
        if (cfgChange) begin
            nextState = IDLE;
            nextTime  = startVal;
            nextDot   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pressReg) nextState = RUN;
                end
                RUN: begin
                    if (bus.tick_1Hz) begin
                        nextTime = stepped;
                        nextDot  = ~dotReg;
                    end
                    // Reaching terminal wins over a simultaneous press.
                    if (bus.tick_1Hz && stepped == terminalVal) begin
                        nextState = DONE;
                        nextDot   = 1'b1;
                    end else if (pressReg) begin
                        nextState = PAUSE;
                        nextDot   = 1'b1;
                    end
                end
                PAUSE: begin
                    if (pressReg) begin
                        nextState = RUN;
                    end else if (!bus.StartStop) begin
                        // Long-press clear: count ticks while the button stays low.
                        nextHold = holdCnt;
                        if (bus.tick_1Hz) begin
                            if (int'(holdCnt) + 1 >= LONG_TICKS) begin
                                nextState = IDLE;
                                nextTime  = startVal;
                                nextHold  = '0;
                            end else begin
                                nextHold = holdCnt + HOLD_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    nextFlash = flashReg ^ bus.tick_flash;
                    if (pressReg) begin
                        nextState = IDLE;
                        nextTime  = startVal;
                        nextFlash = 1'b0;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    assign bus.MinTens     = timeReg[15:12];
    assign bus.MinOnes     = timeReg[11:8];
    assign bus.SecTens     = timeReg[7:4];
    assign bus.SecOnes     = timeReg[3:0];
    assign bus.DOT         = dotReg;
    assign bus.FlashingLED = flashReg;
    assign bus.StopLED     = (state == PAUSE) || (state == DONE);
    assign bus.Running     = (state == RUN);
    assign bus.Done        = (state == DONE);
endmodule

// File: tb/tb_bcd_timer_core.sv
// ---------------------------------------------------------------------------
// tb_bcd_timer_core
// Self-checking bench for bcd_timer_core: expected digit/flag records are
// queued as stimulus is applied and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_bcd_timer_core;
    logic CLK_50MHz = 1'b0;
    logic rst_n     = 1'b0;

    always #5 CLK_50MHz = ~CLK_50MHz;

    bcd_timer_core_if #(.SEL_W(3)) bus ();

    bcd_timer_core #(
        .SEL_W(3), .BASE_MIN(1), .MAX_MIN(99), .LONG_TICKS(2)
    ) dut (
        .CLK_50MHz (CLK_50MHz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    typedef struct {
        string       name;
        logic [15:0] digits;
        logic        run, done, stop, dot, flash;
    } exp_t;

    typedef struct {
        logic        mode;
        logic [2:0]  sel;
        logic [15:0] digits;
    } cfgVec_t;

    exp_t expQ[$];
    int   nCompared = 0;
    int   nMismatch = 0;

    task automatic expectOut(input string nm, input logic [15:0] d, input logic run,
                             input logic done, input logic stop, input logic dot,
                             input logic flash);
        exp_t e;
        e.name = nm; e.digits = d; e.run = run; e.done = done;
        e.stop = stop; e.dot = dot; e.flash = flash;
        expQ.push_back(e);
    endtask

    task automatic checkOut();
        exp_t        e;
        logic [15:0] act;
        logic [4:0]  actF, expF;
        nCompared++;
        if (expQ.size() == 0) begin
            nMismatch++;
            $display("FAIL scoreboard: no expected record queued");
            return;
        end
        e    = expQ.pop_front();
        act  = {bus.MinTens, bus.MinOnes, bus.SecTens, bus.SecOnes};
        actF = {bus.Running, bus.Done, bus.StopLED, bus.DOT, bus.FlashingLED};
        expF = {e.run, e.done, e.stop, e.dot, e.flash};
        if (act !== e.digits || actF !== expF) begin
            nMismatch++;
            $display("FAIL %s: got %h flags(run,done,stop,dot,flash)=%b, required %h flags=%b",
                     e.name, act, actF, e.digits, expF);
        end
    endtask

    // Convert a seconds count to MM:SS BCD (independent of carry logic).
    function automatic logic [15:0] bcdOf(input int sec);
        int m, s;
        m = sec / 60;
        s = sec % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic step();
        @(posedge CLK_50MHz);
        #1;
    endtask

    task automatic tick();
        bus.tick_1Hz = 1'b1;
        step();
        bus.tick_1Hz = 1'b0;
    endtask

    task automatic flashTick();
        bus.tick_flash = 1'b1;
        step();
        bus.tick_flash = 1'b0;
    endtask

    task automatic press();
        bus.StartStop = 1'b0;
        step();
        bus.StartStop = 1'b1;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfgVec_t vt[5];
        vt[0] = '{1'b1, 3'd0, 16'h0100};
        vt[1] = '{1'b1, 3'd7, 16'h0800};
        vt[2] = '{1'b0, 3'd5, 16'h0000};
        vt[3] = '{1'b1, 3'd4, 16'h0500};
        vt[4] = '{1'b1, 3'd1, 16'h0200};

        bus.tick_1Hz    = 1'b0;
        bus.tick_flash  = 1'b0;
        bus.StartStop   = 1'b1;
        bus.ModeSel     = 1'b1;
        bus.TimeControl = 3'd1;
        rst_n           = 1'b0;
        repeat (3) step();

        // Reset state, Mode B preset 2 minutes
        expectOut("reset", 16'h0200, 0, 0, 0, 1, 0); checkOut();
        rst_n = 1'b1;
        step(); step();
        expectOut("post-reset idle", 16'h0200, 0, 0, 0, 1, 0); checkOut();

        // Configuration table: each change reloads the start value in IDLE
        for (int i = 0; i < 5; i++) begin
            bus.ModeSel     = vt[i].mode;
            bus.TimeControl = vt[i].sel;
            step(); step();
            expectOut($sformatf("cfg load %0d", i), vt[i].digits, 0, 0, 0, 1, 0);
            checkOut();
        end

        // Mode A up-count to 01:00
        bus.ModeSel = 1'b0; bus.TimeControl = 3'd0;
        step(); step();
        press();
        expectOut("A start", 16'h0000, 1, 0, 0, 1, 0); checkOut();
        for (int i = 1; i <= 59; i++) begin
            tick();
            expectOut($sformatf("A tick %0d", i), bcdOf(i), 1, 0, 0, (i % 2 == 0), 0);
            checkOut();
        end
        tick();
        expectOut("A terminal", 16'h0100, 0, 1, 1, 1, 0); checkOut();
        flashTick();
        expectOut("A flash on", 16'h0100, 0, 1, 1, 1, 1); checkOut();
        step();
        expectOut("A flash hold", 16'h0100, 0, 1, 1, 1, 1); checkOut();
        flashTick();
        expectOut("A flash off", 16'h0100, 0, 1, 1, 1, 0); checkOut();
        press();
        expectOut("A done->idle", 16'h0000, 0, 0, 0, 1, 0); checkOut();

        // Mode B, pause and long-press clear
        bus.ModeSel = 1'b1; bus.TimeControl = 3'd2;
        step(); step();
        expectOut("B idle", 16'h0300, 0, 0, 0, 1, 0); checkOut();
        press();
        expectOut("B start", 16'h0300, 1, 0, 0, 1, 0); checkOut();
        for (int i = 1; i <= 5; i++) begin
            tick();
            expectOut($sformatf("B tick %0d", i), bcdOf(180 - i), 1, 0, 0, (i % 2 == 0), 0);
            checkOut();
        end
        bus.StartStop = 1'b0;
        step(); step();
        expectOut("B pause", 16'h0255, 0, 0, 1, 1, 0); checkOut();
        tick();
        expectOut("B hold 1", 16'h0255, 0, 0, 1, 1, 0); checkOut();
        tick();
        expectOut("B hold clear", 16'h0300, 0, 0, 0, 1, 0); checkOut();
        bus.StartStop = 1'b1;
        step(); step();
        expectOut("B release", 16'h0300, 0, 0, 0, 1, 0); checkOut();

        // Config change mid-run, then count down to 00:00
        press();
        for (int i = 1; i <= 30; i++) tick();
        expectOut("B 02:30", 16'h0230, 1, 0, 0, 1, 0); checkOut();
        bus.TimeControl = 3'd0;
        step();
        expectOut("B cfg change", 16'h0100, 0, 0, 0, 1, 0); checkOut();
        press();
        expectOut("B restart", 16'h0100, 1, 0, 0, 1, 0); checkOut();
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i < 60)
                expectOut($sformatf("B down %0d", i), bcdOf(60 - i), 1, 0, 0, (i % 2 == 0), 0);
            else
                expectOut("B terminal", 16'h0000, 0, 1, 1, 1, 0);
            checkOut();
        end
        press();
        expectOut("B done->idle", 16'h0100, 0, 0, 0, 1, 0); checkOut();

        // Long hold from IDLE gives one press; press with tick in RUN
        bus.ModeSel = 1'b0;
        step(); step();
        expectOut("A idle", 16'h0000, 0, 0, 0, 1, 0); checkOut();
        bus.StartStop = 1'b0;
        repeat (8000) step();
        expectOut("hold one press", 16'h0000, 1, 0, 0, 1, 0); checkOut();
        bus.StartStop = 1'b1;
        step(); step();
        expectOut("release no press", 16'h0000, 1, 0, 0, 1, 0); checkOut();
        bus.StartStop = 1'b0;
        step();
        bus.StartStop = 1'b1;
        bus.tick_1Hz  = 1'b1;
        step();
        bus.tick_1Hz  = 1'b0;
        expectOut("tick+press", 16'h0001, 0, 0, 1, 1, 0); checkOut();

        // Asynchronous reset mid-run
        press();
        expectOut("resume", 16'h0001, 1, 0, 0, 1, 0); checkOut();
        for (int i = 2; i <= 37; i++) tick();
        expectOut("A 00:37", 16'h0037, 1, 0, 0, 1, 0); checkOut();
        #2;
        rst_n = 1'b0;
        #1;
        expectOut("async reset", 16'h0000, 0, 0, 0, 1, 0); checkOut();
        rst_n = 1'b1;
        step(); step();
        expectOut("after reset", 16'h0000, 0, 0, 0, 1, 0); checkOut();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
